data_mem_module: RTL and testbench
==================================

Name: data_mem_module

Overview:
- Data-memory responder on the far side of the CPU's MEM-stage load/store interface. It receives READ/WRITE requests with byte address, store data and FUNC3.
- Stalls the pipeline through BUSYWAIT for a fixed, parameterised access latency.
- Performs RV32I byte, half and word accesses, little-endian, with sign or zero extension on loads.
- Reports misaligned and illegal requests without modifying memory.

Parameters:
- LATENCY, 5, busy cycles per access (legal range 1..255).
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  load request; held stable by the CPU while BUSYWAIT=1.
- WRITE  input  1  store request; held stable by the CPU while BUSYWAIT=1.
- ADDRESS  input  32  byte address.
- WRITEDATA  input  32  store data; the low byte or half is used for SB/SH.
- FUNC3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- READDATA  output  32  load result; valid only in the DONE cycle.
- BUSYWAIT  output  1  stall request to the pipeline registers.
- ERROR  output  1  one-cycle pulse in DONE for an illegal or misaligned request.

Behaviour:
- Reset values: READDATA=0, ERROR=0, BUSYWAIT=0, state=IDLE, counter=0. Array contents are not cleared by RESET.
- States: IDLE, WAIT, DONE.
- IDLE:
  - BUSYWAIT = READ|WRITE, driven combinationally in the same cycle the request appears.
  - On the edge with a request: if LATENCY==1, go to DONE and perform the access at that edge. Otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - BUSYWAIT=1.
  - Counter==0: perform the access at this edge and go to DONE. Otherwise decrement.
  - If READ and WRITE are both low at an edge, abort to IDLE. No write is performed, ERROR stays 0.
- DONE:
  - BUSYWAIT=0, READDATA registered and valid, ERROR valid. Lasts exactly one cycle, then IDLE.
  - The request is still visible during DONE and is not re-accepted.
  - A new request can be accepted from the cycle after DONE.
- Total BUSYWAIT-high cycles per access = LATENCY exactly.
- Word index = ADDRESS[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte lane = ADDRESS[1:0].
- Loads:
  - B: sign-extends byte lane.
  - BU: zero-extends byte lane.
  - H/HU: lane ADDRESS[1], sign- or zero-extended.
  - W: full word.
- Stores: SB writes 1 byte lane, SH writes 2 lanes, SW writes 4. Other lanes are untouched.
- Illegal cases: no array write, READDATA=0 in DONE, ERROR=1 in DONE. They still take the full LATENCY busy cycles. The cases are:
  - H/HU with ADDRESS[0]=1.
  - W with ADDRESS[1:0]!=0.
  - FUNC3 011, 110 or 111.
  - Store with FUNC3 100 or 101.
  - READ and WRITE both high.
- Request inputs are sampled at the access edge, not at acceptance.
- RESET during WAIT or DONE: next state IDLE, BUSYWAIT=0 the following cycle, no write performed. Previously written data is retained.
- READDATA holds its last value outside DONE. Consumers must not rely on it there.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x10 with LATENCY=5 -> BUSYWAIT high exactly 5 cycles, then DONE. LW @0x10 -> READDATA=0xDEADBEEF in DONE, ERROR=0.
- SB 0x80 @0x11 over word 0x00000000 -> LW @0x10 = 0x00008000. LB @0x11 = 0xFFFFFF80. LBU @0x11 = 0x00000080.
- SH 0x8001 @0x22 -> LH @0x22 = 0xFFFF8001. LHU @0x22 = 0x00008001. LW @0x20 = 0x80010000.
- Misaligned and illegal requests:
  - LW @0x12 -> ERROR=1, READDATA=0.
  - SH @0x13 -> ERROR=1; a following LW @0x10 shows the word unchanged.
  - FUNC3=011 read -> ERROR=1.
- Back-to-back requests: LW immediately after SW DONE -> the new BUSYWAIT rises the cycle after DONE.
  - With LATENCY=1: one busy cycle, then DONE, per access.
- Reset and abort:
  - RESET asserted at WAIT cycle 2 of SW 0x12345678 @0x30 -> IDLE, BUSYWAIT=0; LW @0x30 returns the old value.
  - READ dropped mid-WAIT -> return to IDLE, no DONE pulse.
- Wrap-around: SW 0xA5A5A5A5 @0x400 with DEPTH_WORDS=256 -> LW @0x000 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_module.sv
// Data-memory responder for the MEM-stage load/store port.
// Fixed-latency RV32I byte/half/word access with misalignment and illegal-op reporting.
module data_mem_module #(
   parameter int LATENCY     = 5,
   parameter int DEPTH_WORDS = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITEDATA,
   input  logic [2:0]  FUNC3,
   output logic [31:0] READDATA,
   output logic        BUSYWAIT,
   output logic        ERROR
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [7:0] CNT_INIT =
      (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [31:0]   word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic          legal;
   logic          do_access;
   logic          mem_we;
   logic          unused_addr;

   assign idx         = ADDRESS[AW+1:2];
   assign lane        = ADDRESS[1:0];
   assign unused_addr = ^ADDRESS[31:AW+2];
   assign word        = mem[idx];
   assign byte_sel    = word[{lane, 3'b000} +: 8];
   assign half_sel    = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      legal = 1'b0;
      unique case (FUNC3)
         3'b000:  legal = 1'b1;
         3'b100:  legal = READ;
         3'b001:  legal = ~lane[0];
         3'b101:  legal = READ & ~lane[0];
         3'b010:  legal = (lane == 2'b00);
         default: legal = 1'b0;
      endcase
      if (READ && WRITE) legal = 1'b0;
   end

   always_comb begin
      load_val = 32'd0;
      unique case (FUNC3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'd0, half_sel};
         3'b010:  load_val = word;
         default: load_val = 32'd0;
      endcase
   end

   // Store data is replicated across lanes; the byte enables pick the live lanes.
   always_comb begin
      be    = 4'b0000;
      wdata = WRITEDATA;
      unique case (FUNC3)
         3'b000: begin
            be    = 4'b0001 << lane;
            wdata = {4{WRITEDATA[7:0]}};
         end
         3'b001: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WRITEDATA[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = 1'b0;
      do_access = 1'b0;
      BUSYWAIT  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            BUSYWAIT = READ | WRITE;
            if (READ || WRITE) begin
               if (LATENCY == 1) begin
                  do_access = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            BUSYWAIT = 1'b1;
            if (!READ && !WRITE) begin
               state_d = S_IDLE;
            end else if (cnt_q == 8'd0) begin
               do_access = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (do_access) begin
         err_d   = ~legal;
         rdata_d = (legal && READ) ? load_val : 32'd0;
      end
      if (RESET) begin
         state_d   = S_IDLE;
         cnt_d     = 8'd0;
         rdata_d   = 32'd0;
         err_d     = 1'b0;
         do_access = 1'b0;
      end
   end

   assign mem_we = do_access & WRITE & legal;

   always_ff @(posedge CLK) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign READDATA = rdata_q;
   assign ERROR    = err_q;

endmodule

// File: tb/tb_data_mem_module.sv
// Bench for data_mem_module: LATENCY=5 and LATENCY=1 instances
// checked against an arithmetic model of the memory.
module tb_data_mem_module;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst, rd, wr, busy, err;
   logic [31:0] addr [2];
   logic [31:0] wdat [2];
   logic [31:0] rdat [2];
   logic [2:0]  f3 [2];

   logic [31:0] mm [2][256];
   int n_chk = 0;
   int n_fail = 0;
   int lat [2] = '{5, 1};

   data_mem_module #(.LATENCY(5), .DEPTH_WORDS(256)) u5 (
      .CLK(clk), .RESET(rst[0]), .READ(rd[0]), .WRITE(wr[0]),
      .ADDRESS(addr[0]), .WRITEDATA(wdat[0]), .FUNC3(f3[0]),
      .READDATA(rdat[0]), .BUSYWAIT(busy[0]), .ERROR(err[0])
   );

   data_mem_module #(.LATENCY(1), .DEPTH_WORDS(256)) u1 (
      .CLK(clk), .RESET(rst[1]), .READ(rd[1]), .WRITE(wr[1]),
      .ADDRESS(addr[1]), .WRITEDATA(wdat[1]), .FUNC3(f3[1]),
      .READDATA(rdat[1]), .BUSYWAIT(busy[1]), .ERROR(err[1])
   );

   function automatic bit is_legal(bit r, bit w, logic [31:0] a,
                                   logic [2:0] f);
      if (r && w) return 0;
      case (f)
         3'd0: return 1;
         3'd4: return r;
         3'd1: return (a % 2) == 0;
         3'd5: return r && ((a % 2) == 0);
         3'd2: return (a % 4) == 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(int s, logic [31:0] a,
                                            logic [2:0] f);
      logic [31:0] wd, v;
      wd = mm[s][(a / 4) % 256];
      case (f)
         3'd0, 3'd4: begin
            v = (wd >> (8 * (a % 4))) & 32'hFF;
            if (f == 3'd0 && v >= 128) v = v - 32'd256;
         end
         3'd1, 3'd5: begin
            v = (wd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f == 3'd1 && v >= 32768) v = v - 32'd65536;
         end
         3'd2: v = wd;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   task automatic model_store(int s, logic [31:0] a, logic [31:0] d,
                              logic [2:0] f);
      int i;
      int sh;
      i = int'((a / 4) % 256);
      if (f == 3'd0) begin
         sh = int'(8 * (a % 4));
         mm[s][i] = (mm[s][i] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else if (f == 3'd1) begin
         sh = int'(16 * ((a / 2) % 2));
         mm[s][i] = (mm[s][i] & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end else begin
         mm[s][i] = d;
      end
   endtask

   // Drive one request and hold it until the DONE cycle; returns just after
   // the edge leaving DONE with the request withdrawn.
   task automatic xact(input int s, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, output logic [31:0] q,
                       output logic e, output int nb,
                       output bit first_busy);
      rd[s] = r;
      wr[s] = w;
      addr[s] = a;
      wdat[s] = d;
      f3[s] = f;
      nb = 0;
      first_busy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy[s]) begin
            if (i == 0) first_busy = 1;
            nb++;
         end else begin
            break;
         end
      end
      q = rdat[s];
      e = err[s];
      n_chk++;
      if (nb >= 300) begin
         n_fail++;
         $display("FAIL timeout dut%0d: busy %0d cycles, required %0d",
                  s, nb, lat[s]);
      end
      if (w && is_legal(r, w, a, f)) model_store(s, a, d, f);
      @(posedge clk);
      #1;
      rd[s] = 0;
      wr[s] = 0;
   endtask

   task automatic test_reset;
      rst = 2'b11;
      rd = 0;
      wr = 0;
      for (int s = 0; s < 2; s++) begin
         addr[s] = 0;
         wdat[s] = 0;
         f3[s] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 2'b00;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_chk++;
         if (busy[s] !== 1'b0 || err[s] !== 1'b0 || rdat[s] !== 32'd0) begin
            n_fail++;
            $display("FAIL reset dut%0d: busy=%b err=%b rdata=%h, required 0 0 0",
                     s, busy[s], err[s], rdat[s]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_word;
      logic [31:0] q;
      logic e;
      int nb;
      bit fb;
      xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'd2, q, e, nb, fb);
      n_chk++;
      if (nb !== 5 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_latency: busy=%0d err=%b, required 5 0", nb, e);
      end
      xact(0, 1, 0, 32'h10, 32'h0, 3'd2, q, e, nb, fb);
      n_chk++;
      if (q !== 32'hDEADBEEF || e !== 1'b0 || nb !== 5) begin
         n_fail++;
         $display("FAIL lw: rdata=%h err=%b busy=%0d, required deadbeef 0 5",
                  q, e, nb);
      end
   endtask

   task automatic test_byte;
      logic [31:0] q;
      logic e;
      int nb;
      bit fb;
      logic [31:0] exp [3];
      logic [2:0]  fs [3];
      logic [31:0] as [3];
      exp = '{32'h00008000, 32'hFFFFFF80, 32'h00000080};
      fs = '{3'd2, 3'd0, 3'd4};
      as = '{32'h10, 32'h11, 32'h11};
      xact(0, 0, 1, 32'h10, 32'h0, 3'd2, q, e, nb, fb);
      xact(0, 0, 1, 32'h11, {$urandom_range(255, 1), 24'h000080},
           3'd0, q, e, nb, fb);
      for (int i = 0; i < 3; i++) begin
         xact(0, 1, 0, as[i], 32'h0, fs[i], q, e, nb, fb);
         n_chk++;
         if (q !== exp[i] || e !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_%0d: rdata=%h err=%b, required %h 0",
                     i, q, e, exp[i]);
         end
      end
   endtask

   task automatic test_half;
      logic [31:0] q;
      logic e;
      int nb;
      bit fb;
      logic [31:0] exp [3];
      logic [2:0]  fs [3];
      logic [31:0] as [3];
      exp = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
      fs = '{3'd1, 3'd5, 3'd2};
      as = '{32'h22, 32'h22, 32'h20};
      xact(0, 0, 1, 32'h20, 32'h0, 3'd2, q, e, nb, fb);
      xact(0, 0, 1, 32'h22, 32'h77778001, 3'd1, q, e, nb, fb);
      for (int i = 0; i < 3; i++) begin
         xact(0, 1, 0, as[i], 32'h0, fs[i], q, e, nb, fb);
         n_chk++;
         if (q !== exp[i] || e !== 1'b0) begin
            n_fail++;
            $display("FAIL half_%0d: rdata=%h err=%b, required %h 0",
                     i, q, e, exp[i]);
         end
      end
   endtask

   task automatic test_illegal;
      logic [31:0] q;
      logic e;
      int nb;
      bit fb;
      bit rs [5];
      bit ws [5];
      logic [31:0] as [5];
      logic [2:0]  fs [5];
      rs = '{1, 0, 1, 0, 1};
      ws = '{0, 1, 0, 1, 1};
      as = '{32'h12, 32'h13, 32'h10, 32'h10, 32'h10};
      fs = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd2};
      for (int i = 0; i < 5; i++) begin
         xact(0, rs[i], ws[i], as[i], 32'hFFFFFFFF, fs[i], q, e, nb, fb);
         n_chk++;
         if (e !== 1'b1 || q !== 32'd0 || nb !== 5) begin
            n_fail++;
            $display("FAIL illegal_%0d: err=%b rdata=%h busy=%0d, required 1 0 5",
                     i, e, q, nb);
         end
      end
      @(negedge clk);
      n_chk++;
      if (err[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pulse: err=%b after DONE, required 0", err[0]);
      end
      @(posedge clk);
      #1;
      xact(0, 1, 0, 32'h10, 32'h0, 3'd2, q, e, nb, fb);
      n_chk++;
      if (q !== 32'h00008000 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_nowrite: rdata=%h err=%b, required 00008000 0",
                  q, e);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] q;
      logic e;
      int nb;
      bit fb;
      logic [31:0] d;
      for (int s = 0; s < 2; s++) begin
         d = $urandom;
         xact(s, 0, 1, 32'h14, d, 3'd2, q, e, nb, fb);
         n_chk++;
         if (nb !== lat[s] || fb !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_sw dut%0d: busy=%0d first=%b, required %0d 1",
                     s, nb, fb, lat[s]);
         end
         xact(s, 1, 0, 32'h14, 32'h0, 3'd2, q, e, nb, fb);
         n_chk++;
         if (nb !== lat[s] || fb !== 1'b1 || q !== d) begin
            n_fail++;
            $display("FAIL b2b_lw dut%0d: busy=%0d first=%b rdata=%h, required %0d 1 %h",
                     s, nb, fb, q, lat[s], d);
         end
      end
   endtask

   task automatic test_reset_abort;
      logic [31:0] q;
      logic e;
      int nb;
      int hits;
      bit fb;
      xact(0, 0, 1, 32'h30, 32'h11111111, 3'd2, q, e, nb, fb);
      wr[0] = 1;
      addr[0] = 32'h30;
      wdat[0] = 32'h12345678;
      f3[0] = 3'd2;
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1;
      @(posedge clk);
      #1;
      rst[0] = 0;
      wr[0] = 0;
      @(negedge clk);
      n_chk++;
      if (busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_wait: busy=%b, required 0", busy[0]);
      end
      @(posedge clk);
      #1;
      xact(0, 1, 0, 32'h30, 32'h0, 3'd2, q, e, nb, fb);
      n_chk++;
      if (q !== 32'h11111111) begin
         n_fail++;
         $display("FAIL reset_nowrite: rdata=%h, required 11111111", q);
      end
      for (int k = 0; k < 2; k++) begin
         rd[0] = (k == 0);
         wr[0] = (k == 1);
         addr[0] = (k == 0) ? 32'h10 : 32'h30;
         wdat[0] = 32'hCAFEF00D;
         f3[0] = 3'd2;
         repeat (2) @(posedge clk);
         #1;
         rd[0] = 0;
         wr[0] = 0;
         @(posedge clk);
         #1;
         hits = 0;
         repeat (6) begin
            @(negedge clk);
            if (busy[0] || err[0] || rdat[0] !== 32'h11111111) hits++;
         end
         n_chk++;
         if (hits !== 0) begin
            n_fail++;
            $display("FAIL abort_%0d: %0d active cycles rdata=%h, required 0 11111111",
                     k, hits, rdat[0]);
         end
         @(posedge clk);
         #1;
      end
      xact(0, 1, 0, 32'h30, 32'h0, 3'd2, q, e, nb, fb);
      n_chk++;
      if (q !== 32'h11111111 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_nowrite: rdata=%h err=%b, required 11111111 0", q, e);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] q;
      logic e;
      int nb;
      bit fb;
      xact(0, 0, 1, 32'h400, 32'hA5A5A5A5, 3'd2, q, e, nb, fb);
      xact(0, 1, 0, 32'h000, 32'h0, 3'd2, q, e, nb, fb);
      n_chk++;
      if (q !== 32'hA5A5A5A5 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap: rdata=%h err=%b, required a5a5a5a5 0", q, e);
      end
   endtask

   task automatic test_random;
      logic [31:0] q;
      logic e;
      logic [31:0] a, d, xq;
      logic [2:0] f;
      int nb;
      int op;
      bit fb, r, w, lg;
      for (int s = 0; s < 2; s++) begin
         for (int i = 16; i < 32; i++) begin
            a = 32'(i * 4);
            xact(s, 0, 1, a, $urandom, 3'd2, q, e, nb, fb);
         end
         for (int n = 0; n < 60; n++) begin
            op = $urandom_range(9, 0);
            r = (op < 5) || (op == 9);
            w = (op >= 5);
            a = 32'($urandom_range(127, 64)) | ({$urandom} & 32'hFFFF_F000);
            f = 3'($urandom_range(7, 0));
            d = $urandom;
            lg = is_legal(r, w, a, f);
            xq = lg ? exp_load(s, a, f) : 32'd0;
            xact(s, r, w, a, d, f, q, e, nb, fb);
            n_chk++;
            if (e !== !lg || nb !== lat[s] || (r && !w && q !== xq)) begin
               n_fail++;
               $display("FAIL rand dut%0d r%0d w%0d a=%h f=%0d: rdata=%h err=%b busy=%0d, required %h %b %0d",
                        s, r, w, a, f, q, e, nb, xq, !lg, lat[s]);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_illegal;
      test_back_to_back;
      test_reset_abort;
      test_wrap;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
